vga_scan: RTL and testbench

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan.sv | 99 +++++++++
 tb/tb_vga_scan.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// VGA raster scan generator: pixel tick divider, h/v counters, sync and colour timing.
// Latency: paddr registered 1 clk after the counters move; hs/vs/colour registered on tick for the same pixel.
// Backpressure: none; free-running scan, pdata is sampled on tick whether ready or not.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   pdata        - {R,G,B} colour returned by the framebuffer for the current paddr
//   paddr        - linear pixel address (vcnt*H_VIS+hcnt) in the visible area, 0 elsewhere
//   hs, vs       - active-low horizontal / vertical sync
//   red/green/blue - colour outputs, blanked to 0 outside the visible area
//   frame_start  - one-clk pulse on the tick that ends the last pixel of the frame

module vga_scan #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pdata,
    output logic [18:0] paddr,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS_W = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W = 10'(V_VIS);

    logic [1:0]  div;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        tick;
    logic        h_end;
    logic        v_end;
    logic        visible;
    logic [18:0] lin;

    // One pixel every fourth clk; the divider wraps naturally at 3.
    assign tick    = (div == 2'd3);
    assign h_end   = (hcnt == H_LAST);
    assign v_end   = (vcnt == V_LAST);
    assign visible = (hcnt < H_VIS_W) && (vcnt < V_VIS_W);
    assign lin     = 19'(vcnt) * 19'(H_VIS) + 19'(hcnt);

    // Combinational so it is high in exactly the tick cycle of the last pixel;
    // gated by rst so a reset cycle never reports a frame boundary.
    assign frame_start = tick && h_end && v_end && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= 2'd0;
            hcnt  <= 10'd0;
            vcnt  <= 10'd0;
            paddr <= 19'd0;
            hs    <= 1'b1;
            vs    <= 1'b1;
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else begin
            div <= div + 2'd1;

            // Refreshed every clk: it settles on the clk after a tick, leaving
            // three clks for the framebuffer read before the next tick samples pdata.
            paddr <= visible ? lin : 19'd0;

            if (tick) begin
                // Sync and colour are all derived from the pre-increment counters,
                // so they describe the same pixel and leave together.
                hs <= !((hcnt >= HS_BEG) && (hcnt <= HS_END));
                vs <= !((vcnt >= VS_BEG) && (vcnt <= VS_END));
                {red, green, blue} <= visible ? pdata : 12'h000;

                if (h_end) begin
                    hcnt <= 10'd0;
                    vcnt <= v_end ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: full horizontal timing, shortened vertical timing (8 lines per frame).
// Latency: expectations are pushed at each clk edge and compared at the following negedge.
// Backpressure: none; the bench models a 1-clk framebuffer feeding pdata from paddr.

module tb_vga_scan;

    localparam int HV  = 640;
    localparam int HF  = 16;
    localparam int HSY = 96;
    localparam int HB  = 48;
    localparam int VV  = 4;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pdata = 12'h000;
    logic [18:0] paddr;
    logic        hs;
    logic        vs;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_scan #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pdata(pdata),
        .paddr(paddr),
        .hs(hs),
        .vs(vs),
        .red(red),
        .green(green),
        .blue(blue),
        .frame_start(frame_start)
    );

    // Framebuffer model: constant 12'hABC or an address-derived pattern, 1-clk read latency.
    logic mode_abc = 1'b1;

    function automatic logic [11:0] fb(input logic [18:0] a);
        return mode_abc ? 12'hABC : (a[11:0] ^ {3'b000, a[18:10]});
    endfunction

    always @(posedge clk) pdata <= fb(paddr);

    typedef struct packed {
        logic [18:0] pa;
        logic        hs;
        logic        vs;
        logic [11:0] col;
        logic        fs;
    } obs_t;

    obs_t sbq[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] maddr(input int h, input int v);
        return (h < HV && v < VV) ? 19'(v * HV + h) : 19'd0;
    endfunction

    // Bench model of the scan position, plus output expectations
    int          mdiv = 0;
    int          mh   = 0;
    int          mv   = 0;
    logic        exp_hs  = 1'b1;
    logic        exp_vs  = 1'b1;
    logic [11:0] exp_col = 12'h000;
    logic [18:0] exp_pa  = 19'd0;
    int          pre_h   = 0;
    int          pre_v   = 0;
    logic        ticked  = 1'b0;

    // Waveform measurement trackers
    longint cyc         = 0;
    longint last_hs_fall = -1;
    longint last_fs     = -1;
    int     hs_low_run  = 0;
    int     vs_low_run  = 0;
    int     fs_count    = 0;
    logic   prev_hs     = 1'b1;
    logic   prev_vs     = 1'b1;

    task automatic step();
        obs_t e;
        obs_t o;
        @(posedge clk);
        cyc++;
        ticked = 1'b0;
        if (rst) begin
            mdiv = 0; mh = 0; mv = 0;
            exp_pa = 19'd0; exp_hs = 1'b1; exp_vs = 1'b1; exp_col = 12'h000;
        end else begin
            exp_pa = maddr(mh, mv);
            if (mdiv == 3) begin
                exp_hs  = !(mh >= HV + HF && mh <= HV + HF + HSY - 1);
                exp_vs  = !(mv >= VV + VF && mv <= VV + VF + VSY - 1);
                exp_col = (mh < HV && mv < VV) ? fb(maddr(mh, mv)) : 12'h000;
                pre_h = mh; pre_v = mv; ticked = 1'b1;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
            mdiv = (mdiv + 1) % 4;
        end
        e.pa  = exp_pa;
        e.hs  = exp_hs;
        e.vs  = exp_vs;
        e.col = exp_col;
        e.fs  = !rst && mdiv == 3 && mh == HT - 1 && mv == VT - 1;
        sbq.push_back(e);

        @(negedge clk);
        o.pa  = paddr;
        o.hs  = hs;
        o.vs  = vs;
        o.col = {red, green, blue};
        o.fs  = frame_start;
        e = sbq.pop_front();
        check("scan", 64'(o), 64'(e));

        if (rst) begin
            last_hs_fall = -1; last_fs = -1;
            hs_low_run = 0; vs_low_run = 0;
        end else begin
            if (!hs) hs_low_run++;
            if (prev_hs && !hs) begin
                check("hs_fall_hcnt", 64'(pre_h), 64'd656);
                if (last_hs_fall >= 0) check("line_period", 64'(cyc - last_hs_fall), 64'd3200);
                last_hs_fall = cyc;
            end
            if (!prev_hs && hs) begin
                check("hs_low_clks", 64'(hs_low_run), 64'd384);
                hs_low_run = 0;
            end
            if (!vs) vs_low_run++;
            if (prev_vs && !vs) check("vs_fall_vcnt", 64'(pre_v), 64'(VV + VF));
            if (!prev_vs && vs) begin
                check("vs_low_clks", 64'(vs_low_run), 64'(VSY * HT * 4));
                vs_low_run = 0;
            end
            if (frame_start) begin
                fs_count++;
                if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(HT * VT * 4));
                last_fs = cyc;
            end
        end
        prev_hs = hs;
        prev_vs = vs;
    endtask

    // Point checks at specific scan positions (mdiv==1 means paddr was just loaded)
    task automatic point_checks();
        if (mdiv == 1 && mh == 5 && mv == 2)        check("paddr_5_2", 64'(paddr), 64'd1285);
        if (mdiv == 1 && mh == 639 && mv == VV - 1) check("paddr_last", 64'(paddr), 64'd2559);
        if (mdiv == 1 && mh == 640 && mv == 0)      check("paddr_640_0", 64'(paddr), 64'd0);
        if (mdiv == 1 && mh == 0 && mv == VV)       check("paddr_0_vvis", 64'(paddr), 64'd0);
        if (ticked && mode_abc && pre_h == 100 && pre_v == 1) begin
            check("red_abc", 64'(red), 64'hA);
            check("green_abc", 64'(green), 64'hB);
            check("blue_abc", 64'(blue), 64'hC);
        end
        if (ticked && mode_abc && pre_h == 700 && pre_v == 1)
            check("col_hblank", 64'({red, green, blue}), 64'h0);
        if (ticked && mode_abc && pre_h == 10 && pre_v == VV)
            check("col_vblank", 64'({red, green, blue}), 64'h0);
        if (ticked && !mode_abc && pre_h == 5 && pre_v == 2)
            check("col_pattern", 64'({red, green, blue}), 64'(12'h505 ^ 12'h001));
    endtask

    initial begin
        int n;

        // Reset held for 5 clks
        rst = 1'b1;
        mode_abc = 1'b1;
        repeat (5) step();
        check("rst_hs", 64'(hs), 64'd1);
        check("rst_vs", 64'(vs), 64'd1);
        check("rst_col", 64'({red, green, blue}), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_fs", 64'(frame_start), 64'd0);

        // First tick lands on the 4th edge after release
        rst = 1'b0;
        repeat (3) step();
        check("pre_tick_col", 64'({red, green, blue}), 64'h000);
        step();
        check("first_tick_col", 64'({red, green, blue}), 64'hABC);
        check("first_tick_paddr0", 64'(paddr), 64'd0);
        step();
        check("first_tick_paddr1", 64'(paddr), 64'd1);

        // One full frame, then on into the next frame up to (300,2)
        n = 0;
        while (!(fs_count >= 1 && mh == 300 && mv == 2) && n < 40000) begin
            step();
            point_checks();
            n++;
        end
        check("reach_mid_frame", 64'(n < 40000), 64'd1);
        check("fs_count_frame1", 64'(fs_count), 64'd1);

        // Mid-frame reset: one clk, switch framebuffer contents meanwhile
        rst = 1'b1;
        mode_abc = 1'b0;
        step();
        check("mid_rst_hs", 64'(hs), 64'd1);
        check("mid_rst_vs", 64'(vs), 64'd1);
        check("mid_rst_col", 64'({red, green, blue}), 64'd0);
        check("mid_rst_paddr", 64'(paddr), 64'd0);
        check("mid_rst_fs", 64'(frame_start), 64'd0);
        rst = 1'b0;
        fs_count = 0;
        repeat (5) step();
        check("rescan_paddr", 64'(paddr), 64'd1);

        // Two complete frames after the rescan
        for (int i = 0; i < 2 * HT * VT * 4 + 5; i++) begin
            step();
            point_checks();
        end
        check("fs_count_2frames", 64'(fs_count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
